// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath boundary of the multicycle MIPS core: decode inputs,
// memory handshake, mux selects, strobes and retire/debug status.
interface mips_multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_control;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic [3:0]       state;
    logic             illegal;
    logic             retired;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_en, pc_src,
               alu_src_a, alu_src_b, alu_control, reg_write, reg_dst,
               mem_to_reg, state, illegal, retired, instr_count
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_en, pc_src,
               alu_src_a, alu_src_b, alu_control, reg_write, reg_dst,
               mem_to_reg, state, illegal, retired, instr_count
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences one instruction at a time over the
// shared ALU/register-file/unified-memory datapath and counts retirements.
module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W           = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master ctrl
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC_R  = 4'd6,
        ALUWB_R = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        EXEC_I  = 4'd10,
        ALUWB_I = 4'd11,
        HALT    = 4'd12
    } state_e;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } moore_t;

    function automatic moore_t moore_of(input state_e s);
        moore_t m;
        m = '0;
        case (s)
            FETCH:          begin m.mem_read = 1'b1; m.alu_src_b = 2'b01; end
            DECODE:         m.alu_src_b = 2'b11;
            MEMADR, EXEC_I: begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; end
            MEMRD:          begin m.mem_read = 1'b1; m.iord = 1'b1; end
            MEMWB:          begin m.reg_write = 1'b1; m.mem_to_reg = 1'b1; end
            MEMWR:          begin m.mem_write = 1'b1; m.iord = 1'b1; end
            EXEC_R:         m.alu_src_a = 1'b1;
            ALUWB_R:        begin m.reg_write = 1'b1; m.reg_dst = 1'b1; end
            BRANCH:         begin m.alu_src_a = 1'b1; m.pc_src = 2'b01; end
            JUMP:           m.pc_src = 2'b10;
            ALUWB_I:        m.reg_write = 1'b1;
            HALT:           m.illegal = 1'b1;
            default:        ;
        endcase
        return m;
    endfunction

    state_e           state_q, state_d;
    moore_t           moore_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;
    logic             strobe_ok;
    logic [3:0]       alu_ctrl;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (ctrl.mem_ready) state_d = DECODE;
            DECODE: begin
                case (ctrl.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXEC_R;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = EXEC_I;
                    default:      state_d = HALT_ON_ILLEGAL ? HALT : FETCH;
                endcase
            end
            MEMADR:  state_d = (ctrl.opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (ctrl.mem_ready) state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   if (ctrl.mem_ready) state_d = FETCH;
            EXEC_R:  state_d = ALUWB_R;
            ALUWB_R: state_d = FETCH;
            BRANCH:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            EXEC_I:  state_d = ALUWB_I;
            ALUWB_I: state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Any transition into FETCH from elsewhere is the last cycle of an instruction.
    assign retire  = (state_q != FETCH) && (state_d == FETCH);
    assign count_d = retire ? count_q + CNT_W'(1) : count_q;

    // Moore outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            moore_q <= moore_of(FETCH);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            moore_q <= moore_of(state_d);
            count_q <= count_d;
        end
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        if (state_q == BRANCH) begin
            alu_ctrl = ALU_SUB;
        end else if (state_q == EXEC_R) begin
            case (ctrl.funct)
                6'b100000: alu_ctrl = ALU_ADD;
                6'b100010: alu_ctrl = ALU_SUB;
                6'b100100: alu_ctrl = ALU_AND;
                6'b100101: alu_ctrl = ALU_OR;
                6'b101010: alu_ctrl = ALU_SLT;
                default:   alu_ctrl = ALU_AND;
            endcase
        end
    end

    // Strobes are forced low while reset is held so nothing reaches memory or the register file.
    assign strobe_ok        = ~reset;
    assign ctrl.mem_read    = moore_q.mem_read & strobe_ok;
    assign ctrl.mem_write   = moore_q.mem_write & strobe_ok;
    assign ctrl.reg_write   = moore_q.reg_write & strobe_ok;
    assign ctrl.ir_write    = (state_q == FETCH) & ctrl.mem_ready & strobe_ok;
    assign ctrl.pc_en       = (((state_q == FETCH) & ctrl.mem_ready) |
                               ((state_q == BRANCH) & ctrl.zero) |
                               (state_q == JUMP)) & strobe_ok;
    assign ctrl.iord        = moore_q.iord;
    assign ctrl.pc_src      = moore_q.pc_src;
    assign ctrl.alu_src_a   = moore_q.alu_src_a;
    assign ctrl.alu_src_b   = moore_q.alu_src_b;
    assign ctrl.reg_dst     = moore_q.reg_dst;
    assign ctrl.mem_to_reg  = moore_q.mem_to_reg;
    assign ctrl.illegal     = moore_q.illegal;
    assign ctrl.alu_control = alu_ctrl;
    assign ctrl.state       = state_q;
    assign ctrl.retired     = retire;
    assign ctrl.instr_count = count_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction cycle traces built from the
// instruction-class timing rules, compared every cycle against two DUT configurations.
module tb_mips_multicycle_ctrl;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.CNT_W(32)) if_a ();
    mips_multicycle_ctrl_if #(.CNT_W(4))  if_b ();

    assign if_a.opcode = opcode;
    assign if_a.funct = funct;
    assign if_a.zero = zero;
    assign if_a.mem_ready = mem_ready;
    assign if_b.opcode = opcode;
    assign if_b.funct = funct;
    assign if_b.zero = zero;
    assign if_b.mem_ready = mem_ready;

    mips_multicycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .reset(reset), .ctrl(if_a.master));
    mips_multicycle_ctrl #(.CNT_W(4), .HALT_ON_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .reset(reset), .ctrl(if_b.master));

    typedef struct packed {
        logic [3:0] state;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
        logic       retired;
    } obs_t;

    bit          sel = 1'b0;
    obs_t        act;
    logic [31:0] act_cnt;

    always_comb begin
        if (sel) begin
            act = {if_b.state, if_b.mem_read, if_b.mem_write, if_b.iord, if_b.ir_write,
                   if_b.pc_en, if_b.pc_src, if_b.alu_src_a, if_b.alu_src_b, if_b.alu_control,
                   if_b.reg_write, if_b.reg_dst, if_b.mem_to_reg, if_b.illegal, if_b.retired};
            act_cnt = {28'd0, if_b.instr_count};
        end else begin
            act = {if_a.state, if_a.mem_read, if_a.mem_write, if_a.iord, if_a.ir_write,
                   if_a.pc_en, if_a.pc_src, if_a.alu_src_a, if_a.alu_src_b, if_a.alu_control,
                   if_a.reg_write, if_a.reg_dst, if_a.mem_to_reg, if_a.illegal, if_a.retired};
            act_cnt = if_a.instr_count;
        end
    end

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_cnt = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
        end
    endtask

    logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [3:0] ac_tab [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

    function automatic logic [3:0] ref_alu(input logic [5:0] fn);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < 5; i++) if (fn_tab[i] == fn) r = ac_tab[i];
        return r;
    endfunction

    function automatic int base_cpi(input logic [5:0] op);
        case (op)
            OP_LW:          return 5;
            OP_BEQ, OP_J:   return 3;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] cnt_mask();
        return sel ? 32'h0000_000F : 32'hFFFF_FFFF;
    endfunction

    // Expected outputs for one cycle spent in phase st.
    function automatic obs_t expect_out(input int st, input logic rdy, input logic z,
                                        input logic [5:0] fn, input logic ret);
        obs_t e;
        e = '0;
        e.state = 4'(st);
        e.alu_control = 4'b0010;
        case (st)
            0:  begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_en = rdy; end
            1:  e.alu_src_b = 2'b11;
            2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            3:  begin e.mem_read = 1'b1; e.iord = 1'b1; end
            4:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            5:  begin e.mem_write = 1'b1; e.iord = 1'b1; end
            6:  begin e.alu_src_a = 1'b1; e.alu_control = ref_alu(fn); end
            7:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
            8:  begin e.alu_src_a = 1'b1; e.alu_control = 4'b0110; e.pc_src = 2'b01; e.pc_en = z; end
            9:  begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
            10: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            11: e.reg_write = 1'b1;
            12: e.illegal = 1'b1;
            default: ;
        endcase
        e.retired = ret;
        return e;
    endfunction

    typedef struct {
        int   st;
        logic rdy;
        logic ret;
    } cyc_t;
    cyc_t tr[$];

    task automatic push(input int st, input logic rdy, input logic ret);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.ret = ret;
        tr.push_back(c);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Phase sequence of one instruction: fetch waits, decode, class-specific phases, memory waits.
    task automatic build(input logic [5:0] op, input int wf, input int wd, input bit halt_ill);
        tr.delete();
        for (int i = 0; i < wf; i++) push(0, 1'b0, 1'b0);
        push(0, 1'b1, 1'b0);
        case (op)
            OP_LW: begin
                push(1, rb(), 1'b0); push(2, rb(), 1'b0);
                for (int i = 0; i < wd; i++) push(3, 1'b0, 1'b0);
                push(3, 1'b1, 1'b0); push(4, rb(), 1'b1);
            end
            OP_SW: begin
                push(1, rb(), 1'b0); push(2, rb(), 1'b0);
                for (int i = 0; i < wd; i++) push(5, 1'b0, 1'b0);
                push(5, 1'b1, 1'b1);
            end
            OP_R:    begin push(1, rb(), 1'b0); push(6, rb(), 1'b0); push(7, rb(), 1'b1); end
            OP_BEQ:  begin push(1, rb(), 1'b0); push(8, rb(), 1'b1); end
            OP_J:    begin push(1, rb(), 1'b0); push(9, rb(), 1'b1); end
            OP_ADDI: begin push(1, rb(), 1'b0); push(10, rb(), 1'b0); push(11, rb(), 1'b1); end
            default: begin
                if (halt_ill) begin
                    push(1, rb(), 1'b0);
                    for (int i = 0; i < 10; i++) push(12, rb(), 1'b0);
                end else begin
                    push(1, rb(), 1'b1);
                end
            end
        endcase
    endtask

    task automatic play(input logic [5:0] op, input logic [5:0] fn, input logic z, input int alu_idx,
                        output int ret_at, output logic [3:0] alu_seen);
        opcode = op; funct = fn; zero = z;
        ret_at = 0; alu_seen = '0;
        for (int i = 0; i < tr.size(); i++) begin
            mem_ready = tr[i].rdy;
            @(negedge clk);
            chk($sformatf("out op=%b st=%0d", op, tr[i].st), 64'(act),
                64'(expect_out(tr[i].st, tr[i].rdy, z, fn, tr[i].ret)));
            chk("instr_count", 64'(act_cnt), 64'(model_cnt & cnt_mask()));
            if (act.retired && ret_at == 0) ret_at = i + 1;
            if (i == alu_idx) alu_seen = act.alu_control;
            @(posedge clk); #1;
            if (tr[i].ret) model_cnt++;
        end
    endtask

    task automatic do_reset();
        obs_t e;
        reset = 1'b1; mem_ready = 1'b1; opcode = '0; funct = '0; zero = 1'b1;
        @(negedge clk);
        e = expect_out(0, 1'b1, 1'b1, 6'd0, 1'b0);
        e.mem_read = 1'b0; e.ir_write = 1'b0; e.pc_en = 1'b0;
        chk("reset outputs", 64'(act), 64'(e));
        chk("reset count", 64'(act_cnt), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_cnt = '0;
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         wf;
        int         wd;
        int         exp_cyc;
        logic [3:0] exp_alu;
    } vec_t;

    initial begin
        vec_t       vecs[$];
        logic [5:0] ops [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        int         ret_at;
        logic [3:0] alu_seen;

        vecs.push_back('{OP_R,    6'b100000, 1'b0, 0, 0, 4, 4'b0010});
        vecs.push_back('{OP_R,    6'b100010, 1'b0, 1, 0, 5, 4'b0110});
        vecs.push_back('{OP_R,    6'b100100, 1'b0, 0, 0, 4, 4'b0000});
        vecs.push_back('{OP_R,    6'b100101, 1'b1, 2, 0, 6, 4'b0001});
        vecs.push_back('{OP_R,    6'b101010, 1'b0, 0, 0, 4, 4'b0111});
        vecs.push_back('{OP_R,    6'b000111, 1'b0, 0, 0, 4, 4'b0000});
        vecs.push_back('{OP_LW,   6'b000000, 1'b0, 0, 3, 8, 4'b0010});
        vecs.push_back('{OP_SW,   6'b000000, 1'b0, 1, 2, 7, 4'b0010});
        vecs.push_back('{OP_BEQ,  6'b000000, 1'b1, 0, 0, 3, 4'b0110});
        vecs.push_back('{OP_BEQ,  6'b000000, 1'b0, 0, 0, 3, 4'b0110});
        vecs.push_back('{OP_J,    6'b000000, 1'b0, 0, 0, 3, 4'b0010});
        vecs.push_back('{OP_ADDI, 6'b000000, 1'b1, 0, 0, 4, 4'b0010});
        vecs.push_back('{OP_LW,   6'b000000, 1'b0, 0, 0, 5, 4'b0010});

        sel = 1'b0;
        do_reset();
        foreach (vecs[k]) begin
            build(vecs[k].op, vecs[k].wf, vecs[k].wd, 1'b1);
            play(vecs[k].op, vecs[k].fn, vecs[k].z, vecs[k].wf + 2, ret_at, alu_seen);
            chk($sformatf("cycles vec%0d", k), 64'(ret_at), 64'(vecs[k].exp_cyc));
            chk($sformatf("alu vec%0d", k), 64'(alu_seen), 64'(vecs[k].exp_alu));
        end
        chk("count after table", 64'(act_cnt), 64'(vecs.size()));

        for (int n = 0; n < 150; n++) begin
            logic [5:0] op, fn;
            int         wf, wd;
            op = ops[$urandom_range(0, 5)];
            fn = ($urandom_range(0, 3) != 0) ? fn_tab[$urandom_range(0, 4)] : 6'($urandom);
            wf = $urandom_range(0, 3);
            wd = $urandom_range(0, 3);
            build(op, wf, wd, 1'b1);
            play(op, fn, rb(), wf + 2, ret_at, alu_seen);
            chk("cycles rnd", 64'(ret_at),
                64'(base_cpi(op) + wf + ((op == OP_LW || op == OP_SW) ? wd : 0)));
        end

        // Illegal opcode halts until reset; reset then restores FETCH with count 0.
        do_reset();
        build(OP_ADDI, 0, 0, 1'b1);
        play(OP_ADDI, 6'd0, 1'b0, 2, ret_at, alu_seen);
        build(OP_BAD, 0, 0, 1'b1);
        play(OP_BAD, 6'd0, 1'b0, 2, ret_at, alu_seen);
        chk("halt no retire", 64'(ret_at), 64'd0);
        do_reset();
        build(OP_J, 0, 0, 1'b1);
        play(OP_J, 6'd0, 1'b0, 2, ret_at, alu_seen);

        // Illegal opcode retired as NOP, then counter wrap, on the 4-bit configuration.
        sel = 1'b1;
        do_reset();
        build(OP_BAD, 0, 0, 1'b0);
        play(OP_BAD, 6'd0, 1'b0, 2, ret_at, alu_seen);
        chk("nop retire cycle", 64'(ret_at), 64'd2);
        build(OP_R, 0, 0, 1'b0);
        play(OP_R, 6'b100000, 1'b0, 2, ret_at, alu_seen);
        do_reset();
        for (int n = 0; n < 15; n++) begin
            build(OP_SW, 0, $urandom_range(0, 2), 1'b0);
            play(OP_SW, 6'd0, 1'b0, 2, ret_at, alu_seen);
        end
        chk("count at all-ones", 64'(act_cnt), 64'd15);
        build(OP_SW, 0, 0, 1'b0);
        play(OP_SW, 6'd0, 1'b0, 2, ret_at, alu_seen);
        chk("count wrapped", 64'(act_cnt), 64'd0);
        build(OP_R, 0, 0, 1'b0);
        play(OP_R, 6'b100010, 1'b0, 2, ret_at, alu_seen);

        // Reset asserted mid-cycle while a store waits on memory.
        sel = 1'b0;
        do_reset();
        opcode = OP_SW; funct = '0; zero = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("memwr state", 64'(act.state), 64'd5);
        chk("memwr strobe", 64'(act.mem_write), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("reset drops mem_write", 64'(act.mem_write), 64'd0);
        chk("reset state", 64'(act.state), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_cnt = '0;
        @(negedge clk);
        chk("post-reset state", 64'(act.state), 64'd0);
        chk("post-reset mem_read", 64'(act.mem_read), 64'd1);
        chk("post-reset count", 64'(act_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
